// File: rtl/multicycle_cpu_if.sv
// multicycle_cpu_if: instruction-fetch and output-port handshakes of multicycle_cpu.
interface multicycle_cpu_if #(
  parameter int DATA_W = 8,
  parameter int PC_W = 8
);
  logic              instr_req;
  logic [PC_W-1:0]   instr_addr;
  logic              instr_valid;
  logic [15:0]       instr_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  modport master (
    output instr_req, instr_addr, out_data, out_valid,
    input  instr_valid, instr_data, out_ready
  );
  modport slave (
    input  instr_req, instr_addr, out_data, out_valid,
    output instr_valid, instr_data, out_ready
  );
endinterface

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: 4-register multi-cycle core (FETCH/EXEC/OUTW/HALT) with Z/C flags.
// Defining MULTICYCLE_CPU_MUL_EN turns opcode B into an unsigned multiply.
module multicycle_cpu #(
  parameter int DATA_W = 8,
  parameter int PC_W = 8,
  parameter int NREG = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_cpu_if.master bus,
  output logic             o_zero,
  output logic             o_carry,
  output logic             o_halted
);
  localparam logic [1:0] FETCH = 2'd0, EXEC = 2'd1, OUTW = 2'd2, HALT = 2'd3;
  logic [1:0]        r_state, w_next;
  logic [PC_W-1:0]   r_pc, w_pc_next, w_pc_inc, w_tgt;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] r_out, w_a, w_b, w_imm, w_res;
  logic [DATA_W:0]   w_sum, w_diff;
  logic [3:0]        w_op;
  logic              r_z, r_c, r_req, w_c, w_wr, w_flag;
  assign w_op     = r_ir[15:12];
  assign w_a      = r_regs[r_ir[9:8]];
  assign w_b      = r_regs[r_ir[7:6]];
  assign w_imm    = DATA_W'(r_ir[7:0]);
  assign w_tgt    = r_ir[PC_W-1:0];
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff   = {1'b0, w_a} - {1'b0, w_b};
`ifdef MULTICYCLE_CPU_MUL_EN
  logic [2*DATA_W-1:0] w_prod;
  assign w_prod = {{DATA_W{1'b0}}, w_a} * {{DATA_W{1'b0}}, w_b};
`endif
  always_comb begin
    w_res  = w_op == 4'h0 ? w_sum[DATA_W-1:0] :
             w_op == 4'h1 ? w_diff[DATA_W-1:0] :
             w_op == 4'h2 ? (w_a & w_b) :
             w_op == 4'h3 ? (w_a | w_b) :
             w_op == 4'h4 ? (w_a ^ w_b) :
             w_op == 4'h5 ? ~w_a :
             w_op == 4'h6 ? w_a : w_imm;
    w_c    = w_op == 4'h0 ? w_sum[DATA_W] : w_op == 4'h1 ? w_diff[DATA_W] : 1'b0;
    w_wr   = w_op < 4'h8;
    w_flag = w_op < 4'h6;
`ifdef MULTICYCLE_CPU_MUL_EN
    if (w_op == 4'hB) begin
      w_res  = w_prod[DATA_W-1:0];
      w_c    = |w_prod[2*DATA_W-1:DATA_W];
      w_wr   = 1'b1;
      w_flag = 1'b1;
    end
`endif
  end
  // OUT and HALT hold the PC in EXEC; OUT advances it on the handshake
  always_comb begin
    w_next    = r_state;
    w_pc_next = r_pc;
    if (r_state == FETCH) w_next = (r_req && bus.instr_valid) ? EXEC : FETCH;
    else if (r_state == EXEC) begin
      w_next    = w_op == 4'hA ? OUTW : w_op == 4'hF ? HALT : FETCH;
      w_pc_next = w_op == 4'h8 ? (r_z ? w_tgt : w_pc_inc) :
                  w_op == 4'h9 ? w_tgt :
                  (w_op == 4'hA || w_op == 4'hF) ? r_pc : w_pc_inc;
    end else if (r_state == OUTW && bus.out_ready) begin
      w_next    = FETCH;
      w_pc_next = w_pc_inc;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_req   <= 1'b0;
      r_pc    <= '0;
      r_ir    <= '0;
      r_out   <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      r_req   <= w_next == FETCH;
      r_pc    <= w_pc_next;
      if (r_state == FETCH && r_req && bus.instr_valid) r_ir <= bus.instr_data;
      if (r_state == EXEC) begin
        if (w_wr) r_regs[r_ir[11:10]] <= w_res;
        if (w_flag) {r_z, r_c} <= {w_res == '0, w_c};
        if (w_op == 4'hA) r_out <= w_a;
      end
    end
  end
  assign bus.instr_req  = r_req;
  assign bus.instr_addr = r_pc;
  assign bus.out_valid  = r_state == OUTW;
  assign bus.out_data   = r_out;
  assign o_zero         = r_z;
  assign o_carry        = r_c;
  assign o_halted       = r_state == HALT;
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed programs against multicycle_cpu with a behavioural ROM and consumer.
module tb_multicycle_cpu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic zero, carry, halted;
  always #5 clk = ~clk;
  multicycle_cpu_if #(.DATA_W(8), .PC_W(8)) bus ();
  multicycle_cpu #(.DATA_W(8), .PC_W(8), .NREG(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .o_zero(zero), .o_carry(carry), .o_halted(halted)
  );
  logic [15:0] mem [256];
  int mem_wait = 0;
  int stall = 0;
  int n_vec = 0;
  int n_err = 0;
  int vcyc;
  logic [7:0] fetch_q[$], out_q[$];
  logic z_q[$], c_q[$];
  // instruction memory: answers a request after mem_wait idle cycles
  always @(negedge clk) begin
    if (bus.instr_req) begin
      bus.instr_valid = stall >= mem_wait;
      bus.instr_data  = mem[bus.instr_addr];
      stall = bus.instr_valid ? 0 : stall + 1;
    end else begin
      bus.instr_valid = 1'b0;
      stall = 0;
    end
  end
  always @(posedge clk) begin
    if (!rst_n) begin
      fetch_q.delete(); out_q.delete(); z_q.delete(); c_q.delete();
      vcyc = 0;
    end else begin
      if (bus.instr_req && bus.instr_valid) fetch_q.push_back(bus.instr_addr);
      if (bus.out_valid) vcyc++;
      if (bus.out_valid && bus.out_ready) begin
        out_q.push_back(bus.out_data); z_q.push_back(zero); c_q.push_back(carry);
      end
    end
  end
  function automatic logic [15:0] rr(input logic [3:0] op, input logic [1:0] rd, rs1, rs2);
    return {op, rd, rs1, rs2, 6'd0};
  endfunction
  function automatic logic [15:0] ri(input logic [3:0] op, input logic [1:0] rd, input logic [7:0] imm);
    return {op, rd, 2'd0, imm};
  endfunction
  function automatic logic [7:0] oq(input int i);
    return (out_q.size() > i) ? out_q[i] : 8'hxx;
  endfunction
  function automatic logic [7:0] fq(input int i);
    return (fetch_q.size() > i) ? fetch_q[i] : 8'hxx;
  endfunction
  function automatic logic [1:0] fl(input int i);
    return (z_q.size() > i) ? {z_q[i], c_q[i]} : 2'bxx;
  endfunction
  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic wait_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = halted;
    end
  endtask
  task automatic test_reset;
    clear_mem();
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if ({bus.instr_req, bus.out_valid, halted} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl req/valid/halt=%b want 000", {bus.instr_req, bus.out_valid, halted}); end
    n_vec++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %h want 00", bus.out_data); end
    n_vec++; if ({zero, carry} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {zero, carry}); end
    n_vec++; if (bus.instr_addr !== 8'h00) begin n_err++; $display("FAIL reset_pc got %h want 00", bus.instr_addr); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus.instr_req !== 1'b0) begin n_err++; $display("FAIL release_req got %b want 0", bus.instr_req); end
    @(posedge clk); #1;
    n_vec++; if ({bus.instr_req, bus.instr_addr} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL first_fetch got %b/%h want 1/00", bus.instr_req, bus.instr_addr); end
  endtask
  task automatic test_basic;
    bit ok;
    clear_mem();
    mem[0] = ri(4'h7, 2'd1, 8'd5);
    mem[1] = ri(4'h7, 2'd2, 8'd3);
    mem[2] = rr(4'h0, 2'd3, 2'd1, 2'd2);
    mem[3] = rr(4'hA, 2'd0, 2'd3, 2'd0);
    bus.out_ready = 1'b1;
    do_reset();
    wait_halt(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL basic_halt timeout got 0 want 1"); end
    n_vec++; if (oq(0) !== 8'd8 || out_q.size() != 1) begin n_err++; $display("FAIL basic_out got %h (n=%0d) want 08 (n=1)", oq(0), out_q.size()); end
    n_vec++; if (fl(0) !== 2'b00) begin n_err++; $display("FAIL basic_flags got %b want 00", fl(0)); end
    n_vec++; if (vcyc != 1) begin n_err++; $display("FAIL basic_outw_cycles got %0d want 1", vcyc); end
  endtask
  task automatic test_flags;
    bit ok;
    clear_mem();
    mem[0] = ri(4'h7, 2'd0, 8'hFF);
    mem[1] = ri(4'h7, 2'd1, 8'h01);
    mem[2] = rr(4'h0, 2'd2, 2'd0, 2'd1);
    mem[3] = rr(4'hA, 2'd0, 2'd2, 2'd0);
    mem[4] = rr(4'h1, 2'd3, 2'd1, 2'd0);
    mem[5] = rr(4'hA, 2'd0, 2'd3, 2'd0);
    do_reset();
    wait_halt(ok);
    n_vec++; if (oq(0) !== 8'h00) begin n_err++; $display("FAIL add_wrap got %h want 00", oq(0)); end
    n_vec++; if (fl(0) !== 2'b11) begin n_err++; $display("FAIL add_flags zc got %b want 11", fl(0)); end
    n_vec++; if (oq(1) !== 8'h02) begin n_err++; $display("FAIL sub_borrow got %h want 02", oq(1)); end
    n_vec++; if (fl(1) !== 2'b01) begin n_err++; $display("FAIL sub_flags zc got %b want 01", fl(1)); end
  endtask
  task automatic test_branch;
    logic [7:0] exp [8];
    int i;
    exp = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h12, 8'h13, 8'hFF, 8'h00};
    clear_mem();
    mem[8'h00] = rr(4'h4, 2'd0, 2'd0, 2'd0);
    mem[8'h01] = ri(4'h8, 2'd0, 8'h10);
    mem[8'h10] = ri(4'h7, 2'd1, 8'h01);
    mem[8'h11] = rr(4'h0, 2'd1, 2'd1, 2'd1);
    mem[8'h12] = ri(4'h8, 2'd0, 8'h30);
    mem[8'h13] = ri(4'h9, 2'd0, 8'hFF);
    mem[8'hFF] = 16'hC000;
    do_reset();
    i = 0;
    while (fetch_q.size() < 8 && i < 100) begin @(negedge clk); i++; end
    for (int k = 0; k < 8; k++) begin
      n_vec++; if (fq(k) !== exp[k]) begin n_err++; $display("FAIL branch_fetch[%0d] got %h want %h", k, fq(k), exp[k]); end
    end
    clear_mem();
    mem[0] = ri(4'h9, 2'd0, 8'h00);
    do_reset();
    i = 0;
    while (fetch_q.size() < 4 && i < 100) begin @(negedge clk); i++; end
    n_vec++; if ({fq(3), halted} !== {8'h00, 1'b0}) begin n_err++; $display("FAIL tight_loop got %h/%b want 00/0", fq(3), halted); end
  endtask
  task automatic test_out_stall;
    bit ok;
    int i;
    clear_mem();
    mem[0] = ri(4'h7, 2'd2, 8'h5A);
    mem[1] = rr(4'hA, 2'd0, 2'd2, 2'd0);
    bus.out_ready = 1'b0;
    do_reset();
    i = 0;
    while (!bus.out_valid && i < 50) begin @(negedge clk); i++; end
    for (int k = 0; k < 4; k++) begin
      n_vec++; if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h5A}) begin n_err++; $display("FAIL stall_hold[%0d] got %b/%h want 1/5a", k, bus.out_valid, bus.out_data); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    n_vec++; if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h5A}) begin n_err++; $display("FAIL stall_last got %b/%h want 1/5a", bus.out_valid, bus.out_data); end
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stall_drop got %b want 0", bus.out_valid); end
    wait_halt(ok);
    n_vec++; if (out_q.size() != 1 || vcyc != 5) begin n_err++; $display("FAIL stall_count got n=%0d cyc=%0d want n=1 cyc=5", out_q.size(), vcyc); end
    n_vec++; if (fq(2) !== 8'h02) begin n_err++; $display("FAIL stall_next_fetch got %h want 02", fq(2)); end
  endtask
  task automatic test_fetch_wait_halt;
    bit ok;
    int n;
    clear_mem();
    mem[0] = ri(4'h7, 2'd1, 8'h07);
    mem[1] = rr(4'hA, 2'd0, 2'd1, 2'd0);
    mem_wait = 3;
    bus.out_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++; if ({bus.instr_req, bus.instr_addr} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL wait_hold[%0d] got %b/%h want 1/00", k, bus.instr_req, bus.instr_addr); end
    end
    wait_halt(ok);
    n_vec++; if (oq(0) !== 8'h07) begin n_err++; $display("FAIL wait_out got %h want 07", oq(0)); end
    n = fetch_q.size();
    repeat (6) @(negedge clk);
    n_vec++; if ({halted, bus.instr_req} !== 2'b10 || fetch_q.size() != n || n != 3) begin n_err++; $display("FAIL halt_idle got halt/req=%b%b fetches=%0d want 10 fetches=3", halted, bus.instr_req, fetch_q.size()); end
    mem_wait = 0;
  endtask
  task automatic test_reset_mid_out;
    bit ok;
    int i;
    clear_mem();
    mem[0] = ri(4'h7, 2'd1, 8'h09);
    mem[1] = rr(4'hA, 2'd0, 2'd1, 2'd0);
    bus.out_ready = 1'b0;
    do_reset();
    i = 0;
    while (!bus.out_valid && i < 50) begin @(negedge clk); i++; end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({bus.out_valid, bus.out_data, bus.instr_req} !== {1'b0, 8'h00, 1'b0}) begin n_err++; $display("FAIL async_reset got %b/%h/%b want 0/00/0", bus.out_valid, bus.out_data, bus.instr_req); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    wait_halt(ok);
    n_vec++; if (fq(0) !== 8'h00) begin n_err++; $display("FAIL resume_fetch got %h want 00", fq(0)); end
    n_vec++; if (oq(0) !== 8'h09 || out_q.size() != 1) begin n_err++; $display("FAIL resume_out got %h (n=%0d) want 09 (n=1)", oq(0), out_q.size()); end
  endtask
  task automatic test_mul;
    bit ok;
    clear_mem();
    mem[0] = ri(4'h7, 2'd0, 8'h10);
    mem[1] = ri(4'h7, 2'd1, 8'h10);
    mem[2] = ri(4'h7, 2'd2, 8'h33);
    mem[3] = rr(4'hB, 2'd2, 2'd0, 2'd1);
    mem[4] = rr(4'hA, 2'd0, 2'd2, 2'd0);
    bus.out_ready = 1'b1;
    do_reset();
    wait_halt(ok);
`ifdef MULTICYCLE_CPU_MUL_EN
    n_vec++; if (oq(0) !== 8'h00) begin n_err++; $display("FAIL mul_result got %h want 00", oq(0)); end
    n_vec++; if (fl(0) !== 2'b11) begin n_err++; $display("FAIL mul_flags zc got %b want 11", fl(0)); end
`else
    n_vec++; if (oq(0) !== 8'h33) begin n_err++; $display("FAIL mul_nop_result got %h want 33", oq(0)); end
    n_vec++; if (fl(0) !== 2'b00) begin n_err++; $display("FAIL mul_nop_flags zc got %b want 00", fl(0)); end
`endif
    n_vec++; if (fq(4) !== 8'h04) begin n_err++; $display("FAIL mul_next_pc got %h want 04", fq(4)); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_flags();
    test_branch();
    test_out_stall();
    test_fetch_wait_halt();
    test_reset_mid_out();
    test_mul();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
